// File: rtl/matmul_pool_engine.sv
// ---------------------------------------------------------------------------
// matmul_pool_engine
//
// Computes C = A x B for NxN unsigned DW-bit matrices with per-element
// saturation to DW bits, then reduces C by 2x2 pooling (average or max,
// chosen per run) and writes the (N/2)x(N/2) result one pooled row per word.
// A rows and B columns are fetched over word-wide read ports whose data is
// valid one cycle after the strobe.
//
// Build option: define MATMUL_POOL_BYPASS_EN to add pool_bypass. When set
// for a run, pooling is skipped and all N rows of C are written at full
// width. mem_data_C widens to N*DW in that build.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           run request, sampled only while idle
//   pool_mode       0 = average, 1 = max; latched when a run is accepted
//   pool_bypass     (bypass build only) latched with pool_mode
//   busy, done      run in progress / one-cycle completion pulse
//   mem_*_A         A row read port   (element k at [k*DW +: DW])
//   mem_*_B         B column read port (element k = B[k][j])
//   mem_*_C         result write port  (element c at [c*DW +: DW])
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module matmul_pool_engine #(
   parameter int            N      = 4,
   parameter int            DW     = 8,
   parameter int            AW     = 10,
   parameter logic [AW-1:0] BASE_A = AW'('h000),
   parameter logic [AW-1:0] BASE_B = AW'('h100),
   parameter logic [AW-1:0] BASE_C = AW'('h200)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            pool_mode,
`ifdef MATMUL_POOL_BYPASS_EN
   input  logic            pool_bypass,
`endif
   output logic            busy,
   output logic            done,
   output logic            mem_rd_en_A,
   output logic [AW-1:0]   mem_addr_A,
   input  logic [N*DW-1:0] mem_data_A,
   output logic            mem_rd_en_B,
   output logic [AW-1:0]   mem_addr_B,
   input  logic [N*DW-1:0] mem_data_B,
   output logic            mem_wr_en_C,
   output logic [AW-1:0]   mem_addr_C,
`ifdef MATMUL_POOL_BYPASS_EN
   output logic [N*DW-1:0] mem_data_C
`else
   output logic [(N/2)*DW-1:0] mem_data_C
`endif
);

   localparam int IW   = $clog2(N);
   localparam int ACCW = 2*DW + $clog2(N);
   localparam int CW   = $bits(mem_data_C);
   localparam logic [IW-1:0] LAST  = IW'(N-1);
   localparam logic [IW-1:0] HLAST = IW'(N/2-1);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_A, S_CAP_A, S_RD_B, S_CAP_B,
      S_MAC, S_STORE, S_POOL, S_WRITE, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0]   a_q [N];
   logic [DW-1:0]   b_q [N];
   logic [DW-1:0]   c_q [N][N];
   logic [ACCW-1:0] acc_q;
   logic [IW-1:0]   i_q, j_q, k_q;
   logic [IW-1:0]   pr_q, pc_q;
   logic [IW-1:0]   r_q;
   logic            mode_q;
   logic            bypass_act;

`ifdef MATMUL_POOL_BYPASS_EN
   logic bypass_q;
   assign bypass_act = bypass_q;
`else
   assign bypass_act = 1'b0;
`endif

   // Last write row: N/2 pooled rows, or all N rows of C when bypassing.
   logic [IW-1:0] wr_last;
   assign wr_last = bypass_act ? LAST : HLAST;

   // ---------------- datapath helpers ----------------
   logic [2*DW-1:0] prod;
   logic [DW-1:0]   sat_val;
   assign prod    = (2*DW)'(a_q[k_q]) * (2*DW)'(b_q[k_q]);
   assign sat_val = (acc_q > ACCW'({DW{1'b1}})) ? {DW{1'b1}} : acc_q[DW-1:0];

   // 2x2 window for pooled element (pr, pc).
   logic [IW-1:0]   r0, r1, c0, c1;
   logic [DW-1:0]   e00, e01, e10, e11, mx_top, mx_bot, mx;
   logic [DW+1:0]   sum4;
   logic [DW-1:0]   pool_val;

   assign r0 = pr_q << 1;
   assign r1 = r0 | IW'(1);
   assign c0 = pc_q << 1;
   assign c1 = c0 | IW'(1);
   assign e00 = c_q[r0][c0];
   assign e01 = c_q[r0][c1];
   assign e10 = c_q[r1][c0];
   assign e11 = c_q[r1][c1];
   assign sum4 = (DW+2)'(e00) + (DW+2)'(e01) + (DW+2)'(e10) + (DW+2)'(e11);
   assign mx_top = (e00 > e01) ? e00 : e01;
   assign mx_bot = (e10 > e11) ? e10 : e11;
   assign mx     = (mx_top > mx_bot) ? mx_top : mx_bot;
   assign pool_val = mode_q ? mx : sum4[DW+1:2];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RD_A;
         S_RD_A:  state_d = S_CAP_A;
         S_CAP_A: state_d = S_RD_B;
         S_RD_B:  state_d = S_CAP_B;
         S_CAP_B: state_d = S_MAC;
         S_MAC:   if (k_q == LAST) state_d = S_STORE;
         S_STORE: begin
            if (j_q != LAST)      state_d = S_RD_B;
            else if (i_q != LAST) state_d = S_RD_A;
            else if (bypass_act)  state_d = S_WRITE;
            else                  state_d = S_POOL;
         end
         S_POOL:  if (pr_q == HLAST && pc_q == HLAST) state_d = S_WRITE;
         S_WRITE: if (r_q == wr_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the operand and result buffers are reset as well, so a run
         // started after an abort never sees data from the aborted run.
         for (int k = 0; k < N; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            for (int m = 0; m < N; m++) c_q[k][m] <= '0;
         end
         acc_q  <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         pr_q   <= '0;
         pc_q   <= '0;
         r_q    <= '0;
         mode_q <= 1'b0;
`ifdef MATMUL_POOL_BYPASS_EN
         bypass_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every read in this
         // block sees the value from before the clock edge.
         case (state_q)
            S_IDLE: if (start) begin
               mode_q <= pool_mode;
`ifdef MATMUL_POOL_BYPASS_EN
               bypass_q <= pool_bypass;
`endif
               i_q  <= '0;
               j_q  <= '0;
               pr_q <= '0;
               pc_q <= '0;
               r_q  <= '0;
            end
            S_CAP_A: for (int k = 0; k < N; k++) a_q[k] <= mem_data_A[k*DW +: DW];
            S_CAP_B: begin
               for (int k = 0; k < N; k++) b_q[k] <= mem_data_B[k*DW +: DW];
               acc_q <= '0;
               k_q   <= '0;
            end
            S_MAC: begin
               acc_q <= acc_q + ACCW'(prod);
               k_q   <= k_q + IW'(1);
            end
            S_STORE: begin
               c_q[i_q][j_q] <= sat_val;
               if (j_q != LAST) begin
                  j_q <= j_q + IW'(1);
               end else begin
                  j_q <= '0;
                  if (i_q != LAST) i_q <= i_q + IW'(1);
               end
            end
            S_POOL: begin
               // Pooled results overwrite C in place at [pr][pc]. In row-major
               // order that cell is never part of a later, unvisited window.
               c_q[pr_q][pc_q] <= pool_val;
               if (pc_q == HLAST) begin
                  pc_q <= '0;
                  pr_q <= pr_q + IW'(1);
               end else begin
                  pc_q <= pc_q + IW'(1);
               end
            end
            S_WRITE: r_q <= r_q + IW'(1);
            default: ;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy        = (state_q != S_IDLE) && (state_q != S_DONE);
      done        = (state_q == S_DONE);
      mem_rd_en_A = 1'b0;
      mem_addr_A  = '0;
      mem_rd_en_B = 1'b0;
      mem_addr_B  = '0;
      mem_wr_en_C = 1'b0;
      mem_addr_C  = '0;
      mem_data_C  = '0;
      case (state_q)
         S_RD_A: begin
            mem_rd_en_A = 1'b1;
            mem_addr_A  = BASE_A + AW'(i_q);
         end
         S_RD_B: begin
            mem_rd_en_B = 1'b1;
            mem_addr_B  = BASE_B + AW'(j_q);
         end
         S_WRITE: begin
            mem_wr_en_C = 1'b1;
            mem_addr_C  = BASE_C + AW'(r_q);
            for (int c = 0; c < CW/DW; c++)
               if (c < N/2 || bypass_act) mem_data_C[c*DW +: DW] = c_q[r_q][c];
         end
         default: ;
      endcase
   end

endmodule
